leds_pwm_bank: RTL and testbench

//  Parametrised LED register bank: next generation of the single-word LED latch.

---
 rtl/leds_pwm_bank.sv | 163 ++++++++++++++++
 tb/tb_leds_pwm_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/leds_pwm_bank.sv
// leds_pwm_bank: LED register bank with per-LED blink, global PWM brightness
// and a programmable blink rate. Word-addressed slave on the data_m_* port.
//
// Bus handshake: the master raises data_m_access (with cs) and holds it until
// it sees data_m_ack. The slave answers every cycle in which cs & access was
// seen on the previous edge with a one-cycle ack; read data is valid in the
// same cycle as ack and is 0 otherwise. Writes commit on the request edge, so
// a held access simply re-acks (and rewrites) until the master drops it.
module leds_pwm_bank #(
   parameter int LED_WIDTH  = 16,
   parameter int PWM_BITS   = 8,
   parameter int PRESC_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cs,
   input  logic [1:0]           data_m_addr,
   input  logic [15:0]          data_m_data_in,
   output logic [15:0]          data_m_data_out,
   input  logic                 data_m_access,
   output logic                 data_m_ack,
   input  logic                 data_m_wr_en,
   input  logic [1:0]           data_m_bytesel,
   input  logic                 resetval,
   output logic [LED_WIDTH-1:0] leds_val
);

   localparam logic [1:0] A_VALUE  = 2'd0;
   localparam logic [1:0] A_BLINK  = 2'd1;
   localparam logic [1:0] A_BRIGHT = 2'd2;
   localparam logic [1:0] A_PERIOD = 2'd3;

   logic [LED_WIDTH-1:0]  value_q;
   logic [LED_WIDTH-1:0]  blink_q;
   logic [PWM_BITS-1:0]   bright_q;
   logic [15:0]           period_q;
   logic [PRESC_BITS-1:0] presc_q;
   logic [15:0]           bcnt_q;
   logic                  phase_q;
   logic [PWM_BITS-1:0]   pcnt_q;

   logic        wr_stb;
   logic        rd_stb;
   logic        period_wr;
   logic        tick;
   logic        pwm_on;
   logic [15:0] period_m1;
   logic [15:0] rd_mux;
   logic [15:0] value_nxt;
   logic [15:0] blink_nxt;
   logic [15:0] bright_nxt;
   logic [15:0] period_nxt;

   // Replace the byte lanes selected by bs in old with the bus write data.
   function automatic logic [15:0] lane_merge(input logic [15:0] old,
                                              input logic [15:0] wd,
                                              input logic [1:0]  bs);
      logic [15:0] r;
      r = old;
      if (bs[0]) r[7:0]  = wd[7:0];
      if (bs[1]) r[15:8] = wd[15:8];
      return r;
   endfunction

   assign wr_stb    = cs & data_m_access & data_m_wr_en;
   assign rd_stb    = cs & data_m_access & ~data_m_wr_en;
   assign period_wr = wr_stb & (data_m_addr == A_PERIOD);
   assign tick      = &presc_q;
   assign pwm_on    = (pcnt_q < bright_q) | (&bright_q);
   // A PERIOD of 0 behaves as 1, so the wrap point is never below 0.
   assign period_m1 = (period_q == 16'd0) ? 16'd0 : period_q - 16'd1;

   // Next register contents; resetval clears VALUE underneath any lane write.
   always_comb begin
      value_nxt  = resetval ? 16'd0 : 16'(value_q);
      blink_nxt  = 16'(blink_q);
      bright_nxt = 16'(bright_q);
      period_nxt = period_q;
      if (wr_stb) begin
         case (data_m_addr)
            A_VALUE:  value_nxt  = lane_merge(value_nxt,  data_m_data_in, data_m_bytesel);
            A_BLINK:  blink_nxt  = lane_merge(blink_nxt,  data_m_data_in, data_m_bytesel);
            A_BRIGHT: bright_nxt = lane_merge(bright_nxt, data_m_data_in, data_m_bytesel);
            default:  period_nxt = lane_merge(period_nxt, data_m_data_in, data_m_bytesel);
         endcase
      end
   end

   // Read mux, zero-extended to the 16-bit bus.
   always_comb begin
      rd_mux = 16'd0;
      case (data_m_addr)
         A_VALUE:  rd_mux = 16'(value_q);
         A_BLINK:  rd_mux = 16'(blink_q);
         A_BRIGHT: rd_mux = 16'(bright_q);
         default:  rd_mux = period_q;
      endcase
   end

   // Register file.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         value_q  <= '0;
         blink_q  <= '0;
         bright_q <= '1;
         period_q <= 16'd1;
      end else begin
         value_q  <= value_nxt[LED_WIDTH-1:0];
         blink_q  <= blink_nxt[LED_WIDTH-1:0];
         bright_q <= bright_nxt[PWM_BITS-1:0];
         period_q <= period_nxt;
      end
   end

   // Bus response: one-cycle ack, read data only on read acks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_m_ack      <= 1'b0;
         data_m_data_out <= 16'd0;
      end else begin
         data_m_ack      <= cs & data_m_access;
         data_m_data_out <= rd_stb ? rd_mux : 16'd0;
      end
   end

   // Free-running prescaler and PWM counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         pcnt_q  <= '0;
      end else begin
         presc_q <= presc_q + 1'b1;
         pcnt_q  <= pcnt_q + 1'b1;
      end
   end

   // Blink half-period counter; a PERIOD write restarts it without touching phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bcnt_q  <= 16'd0;
         phase_q <= 1'b1;
      end else if (period_wr) begin
         bcnt_q  <= 16'd0;
      end else if (tick) begin
         if (bcnt_q >= period_m1) begin
            bcnt_q  <= 16'd0;
            phase_q <= ~phase_q;
         end else begin
            bcnt_q  <= bcnt_q + 16'd1;
         end
      end
   end

   // Registered LED drive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         leds_val <= '0;
      end else begin
         leds_val <= value_q & (~blink_q | {LED_WIDTH{phase_q}}) & {LED_WIDTH{pwm_on}};
      end
   end

endmodule

// File: tb/tb_leds_pwm_bank.sv
// tb_leds_pwm_bank: directed test of leds_pwm_bank. The DUT is built with
// PWM_BITS=4 and PRESC_BITS=2 so blink and PWM periods stay short; the
// all-ones BRIGHT reset value is therefore 16'h000F.
module tb_leds_pwm_bank;

   logic        clk;
   logic        reset_n;
   logic        cs;
   logic [1:0]  data_m_addr;
   logic [15:0] data_m_data_in;
   logic [15:0] data_m_data_out;
   logic        data_m_access;
   logic        data_m_ack;
   logic        data_m_wr_en;
   logic [1:0]  data_m_bytesel;
   logic        resetval;
   logic [15:0] leds_val;

   int total = 0;
   int bad   = 0;
   int bit1_low = 0;

   leds_pwm_bank #(.LED_WIDTH(16), .PWM_BITS(4), .PRESC_BITS(2)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .cs              (cs),
      .data_m_addr     (data_m_addr),
      .data_m_data_in  (data_m_data_in),
      .data_m_data_out (data_m_data_out),
      .data_m_access   (data_m_access),
      .data_m_ack      (data_m_ack),
      .data_m_wr_en    (data_m_wr_en),
      .data_m_bytesel  (data_m_bytesel),
      .resetval        (resetval),
      .leds_val        (leds_val)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
   endtask

   // driver tasks: drive on negedge, sample on the following negedge
   task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] bs);
      @(negedge clk);
      cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
      data_m_addr = a; data_m_data_in = d; data_m_bytesel = bs;
      @(negedge clk);
      chk("wr_ack", data_m_ack, 1);
      chk("wr_dout0", data_m_data_out, 0);
      cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, input string tag, input logic [15:0] exp);
      @(negedge clk);
      chk({tag, "_ack_pre"}, data_m_ack, 0);
      cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = a;
      @(negedge clk);
      chk({tag, "_ack"}, data_m_ack, 1);
      chk(tag, data_m_data_out, exp);
      cs = 1'b0; data_m_access = 1'b0;
   endtask

   // cycles until leds_val[0] changes; also watches that bit1 stays lit
   task automatic wait_toggle(output int n);
      logic prev;
      prev = leds_val[0];
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!leds_val[1]) bit1_low++;
      end while (leds_val[0] == prev && n < 100);
   endtask

   initial begin
      int n;
      int hi;
      int lo;
      cs = 0; data_m_addr = 0; data_m_data_in = 0; data_m_access = 0;
      data_m_wr_en = 0; data_m_bytesel = 0; resetval = 0;
      apply_reset();

      // 1: reset values
      chk("rst_leds", leds_val, 0);
      chk("rst_ack", data_m_ack, 0);
      bus_read(2'd0, "rst_value", 16'h0000);
      bus_read(2'd1, "rst_blink", 16'h0000);
      bus_read(2'd2, "rst_bright", 16'h000F);
      bus_read(2'd3, "rst_period", 16'h0001);

      // 2: byte-lane writes
      bus_write(2'd0, 16'hA5C3, 2'b01);
      bus_read(2'd0, "lane_lo", 16'h00C3);
      bus_write(2'd0, 16'h5A00, 2'b10);
      @(negedge clk);
      chk("lane_leds", leds_val, 16'h5AC3);
      bus_read(2'd0, "lane_both", 16'h5AC3);

      // 3: resetval versus a coincident write, then alone
      resetval = 1'b1;
      bus_write(2'd0, 16'h0F0F, 2'b11);
      resetval = 1'b0;
      bus_read(2'd0, "rv_write_wins", 16'h0F0F);
      chk("rv_leds_before", leds_val, 16'h0F0F);
      @(negedge clk);
      resetval = 1'b1;
      @(negedge clk);
      resetval = 1'b0;
      chk("rv_leds_lag", leds_val, 16'h0F0F);
      @(negedge clk);
      chk("rv_leds_clr", leds_val, 16'h0000);
      bus_read(2'd0, "rv_value_clr", 16'h0000);

      // 4: blink with PERIOD=3 (12 clk) and PERIOD=0 (4 clk)
      bus_write(2'd0, 16'h0003, 2'b11);
      bus_write(2'd1, 16'h0001, 2'b11);
      bus_write(2'd3, 16'h0003, 2'b11);
      wait_toggle(n);
      wait_toggle(n);
      chk("blink_p3_a", n, 12);
      wait_toggle(n);
      chk("blink_p3_b", n, 12);
      bus_write(2'd3, 16'h0000, 2'b11);
      wait_toggle(n);
      wait_toggle(n);
      chk("blink_p0_a", n, 4);
      wait_toggle(n);
      chk("blink_p0_b", n, 4);
      chk("blink_bit1_steady", bit1_low, 0);

      // 5: PWM duty
      bus_write(2'd1, 16'h0000, 2'b11);
      bus_write(2'd0, 16'hFFFF, 2'b11);
      bus_write(2'd2, 16'h0004, 2'b11);
      repeat (2) @(negedge clk);
      hi = 0; lo = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (leds_val == 16'hFFFF) hi++;
         if (leds_val == 16'h0000) lo++;
      end
      chk("pwm4_hi", hi, 4);
      chk("pwm4_lo", lo, 12);
      bus_write(2'd2, 16'h0000, 2'b11);
      repeat (2) @(negedge clk);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (leds_val != 16'h0000) hi++;
      end
      chk("pwm0_off", hi, 0);
      bus_write(2'd2, 16'h000F, 2'b11);
      repeat (2) @(negedge clk);
      lo = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (leds_val != 16'hFFFF) lo++;
      end
      chk("pwm15_on", lo, 0);

      // 6: async reset during a held read
      bus_write(2'd0, 16'h1234, 2'b11);
      bus_write(2'd1, 16'hFFFF, 2'b11);
      bus_write(2'd3, 16'h0009, 2'b11);
      bus_write(2'd2, 16'h0003, 2'b11);
      @(negedge clk);
      cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0; data_m_addr = 2'd0;
      @(posedge clk);
      #2;
      chk("ar_ack_before", data_m_ack, 1);
      chk("ar_dout_before", data_m_data_out, 16'h1234);
      reset_n = 1'b0;
      #1;
      chk("ar_ack", data_m_ack, 0);
      chk("ar_dout", data_m_data_out, 0);
      chk("ar_leds", leds_val, 0);
      @(negedge clk);
      chk("ar_ack_held", data_m_ack, 0);
      cs = 1'b0; data_m_access = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      bus_read(2'd0, "ar_value", 16'h0000);
      bus_read(2'd1, "ar_blink", 16'h0000);
      bus_read(2'd2, "ar_bright", 16'h000F);
      bus_read(2'd3, "ar_period", 16'h0001);
      chk("ar_leds_after", leds_val, 0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
